bus_mem: RTL

Word-addressed main memory that sits on the far end of the CPU's shared memory bus: it answers CPU reads by driving `data_bus` and commits CPU writes from `data_bus`. It also contains a host program loader (valid/ready stream) that holds the CPU in reset while a program image is written from address 0 upward. It is the responder counterpart of the CPU's bus master port and is instantiated beside the CPU at top level.

---
 rtl/bus_mem_pkg.sv | 18 +
 rtl/bus_mem_ram.sv | 27 ++
 rtl/bus_mem.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the bus-side main memory and its program loader.
package bus_mem_pkg;

  // Controller states: normal CPU service, image streaming, one-cycle completion.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the shared CPU data bus.
  localparam int BUS_W = 16;

  // Encoding of the CPU bus direction line.
  localparam logic WR_READ  = 1'b1;
  localparam logic WR_WRITE = 1'b0;

endpackage

// File: rtl/bus_mem_ram.sv
// Word array with one synchronous write port and one asynchronous read port.
// Contents are deliberately never cleared so a loaded image survives reset.
module bus_mem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port: commit one word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is combinational so CPU reads complete in the same cycle.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_mem.sv
// Responder side of the CPU memory bus plus a valid/ready program loader that
// holds the CPU in reset while an image is streamed in from address 0 upward.
module bus_mem
  import bus_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [BUS_W-1:0]  address_bus,
  inout  wire  [BUS_W-1:0]  data_bus,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [BUS_W-1:0]  ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_ovf,
  output logic [ADDR_W:0]   ld_count,
  output logic              cpu_hold,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [BUS_W-1:0]   ram_wdata;
  logic [BUS_W-1:0]   ram_rdata;

  logic               addr_oor;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [ADDR_W-1:0]  load_addr;
  logic [ADDR_W:0]    load_count;
  logic               xfer;
  logic               bus_en;
  logic [BUS_W-1:0]   bus_val;

  // Any address bit above the implemented range marks an invalid access.
  assign addr_oor = (address_bus >> ADDR_W) != '0;
  assign cpu_addr = address_bus[ADDR_W-1:0];

  // A restart in the same cycle as a transfer writes from address 0.
  assign load_addr  = ld_start ? '0 : ptr_q;
  assign load_count = ld_start ? '0 : count_q;
  assign xfer       = (state_q == LOAD) && ld_valid;

  bus_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (BUS_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cpu_addr),
    .rdata (ram_rdata)
  );

  // Next-state logic: FSM transitions, loader pointer/counter and write-port mux.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_waddr = cpu_addr;
    ram_wdata = data_bus;

    case (state_q)
      RUN: begin
        if (addr_oor) begin
          err_d = 1'b1;
        end else if (wr == WR_WRITE) begin
          ram_we = 1'b1;
        end
        // Starting a load opens a fresh error/overflow window.
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        if (ld_start) begin
          ptr_d   = '0;
          count_d = '0;
        end
        if (xfer) begin
          ram_we    = 1'b1;
          ram_waddr = load_addr;
          ram_wdata = ld_data;
          count_d   = load_count + CNT_ONE;
          // The pointer saturates at the top word instead of wrapping.
          if (load_addr == PTR_MAX) begin
            ptr_d = load_addr;
            if (!ld_last) begin
              ovf_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            ptr_d = load_addr + PTR_ONE;
          end
          if (ld_last) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register with synchronous reset; memory contents are untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign ld_ready = (state_q == LOAD);
  assign ld_done  = (state_q == DONE);
  assign cpu_hold = (state_q != RUN);
  assign ld_ovf   = ovf_q;
  assign ld_count = count_q;
  assign addr_err = err_q;

  // Only a CPU read in RUN may drive the shared bus; invalid addresses read as zero.
  assign bus_en   = (state_q == RUN) && (wr == WR_READ);
  assign bus_val  = addr_oor ? '0 : ram_rdata;
  assign data_bus = bus_en ? bus_val : 'z;

endmodule
